// File: rtl/ps2_pkg.sv
`default_nettype none
//==============================================================================
// ps2_pkg - shared types and constants for the PS/2 receiver. Rev 1.0
//==============================================================================
package ps2_pkg;

    localparam int PS2_DATA_BITS  = 8;
    localparam int PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        ERR_TIMEOUT  = 2'd0,
        ERR_PARITY   = 2'd1,
        ERR_FRAME    = 2'd2,
        ERR_OVERFLOW = 2'd3
    } ps2_err_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

endpackage
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
//==============================================================================
// ps2_rx_fifo - show-ahead byte FIFO; a push while full lands only with a pop. Rev 1.0
//==============================================================================
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_BITS = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_push,
    input  logic [7:0]           i_data,
    input  logic                 i_pop,
    output logic [7:0]           o_data,
    output logic                 o_valid,
    output logic                 o_full,
    output logic                 o_overflow,
    output logic [FIFO_BITS:0]   o_count
);

    localparam int                c_DEPTH = 1 << FIFO_BITS;
    localparam logic [FIFO_BITS:0] c_FULL = (FIFO_BITS + 1)'(c_DEPTH);

    logic [PS2_DATA_BITS-1:0] r_mem [c_DEPTH];
    logic [FIFO_BITS-1:0]     r_wptr;
    logic [FIFO_BITS-1:0]     r_rptr;
    logic [FIFO_BITS:0]       r_count;
    logic                     w_empty;
    logic                     w_full;
    logic                     w_pop;
    logic                     w_wr;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL);
    assign w_pop   = i_pop & ~w_empty;
    // A pop in the same cycle frees the slot the push is about to take.
    assign w_wr    = i_push & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data     = w_empty ? '0 : r_mem[r_rptr];
    assign o_valid    = ~w_empty;
    assign o_full     = w_full;
    assign o_overflow = i_push & ~w_wr;
    assign o_count    = r_count;

endmodule
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
//==============================================================================
// ps2_rx - PS/2 11-bit frame receiver feeding a show-ahead byte FIFO.
// Optional abandoned-frame timeout: define PS2_RX_TIMEOUT_EN. Rev 1.0
//==============================================================================
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_BITS = 3,
    parameter int TIMEOUT   = 8192
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 ps2_clk,
    input  logic                 ps2_data,
    output logic [7:0]           rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_err,
    output logic [1:0]           rx_err_code,
    output logic [FIFO_BITS:0]   fifo_count
);

    logic                     r_clk_s1, r_clk_s2, r_clk_d;
    logic                     r_dat_s1, r_dat_s2;
    logic                     w_fall;

    ps2_state_e               r_state, w_state_nxt;
    logic [PS2_DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic [2:0]               r_bitcnt, w_cnt_nxt;
    logic                     r_par, w_par_nxt;
    logic                     r_perr, w_perr_nxt;
    logic                     w_push, w_frame_err, w_par_fail, w_timeout, w_ovf;
    logic                     w_full;
    logic                     w_err_any;
    ps2_err_e                 w_code;
    logic                     r_err;
    logic [1:0]               r_code;

    // Sync flops reset high so a release never looks like a falling edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_clk_d  <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_clk_d  <= r_clk_s2;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    assign w_fall = r_clk_d & ~r_clk_s2;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT + 1);
    logic [c_TO_W-1:0] r_to_cnt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt <= '0;
        end else if ((r_state == ST_IDLE) || w_fall) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state != ST_IDLE) && !w_fall && (r_to_cnt == c_TO_W'(TIMEOUT - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT;
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_par    <= 1'b1;
            r_perr   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_bitcnt <= w_cnt_nxt;
            r_par    <= w_par_nxt;
            r_perr   <= w_perr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_bitcnt;
        w_par_nxt   = r_par;
        w_perr_nxt  = r_perr;
        w_push      = 1'b0;
        w_frame_err = 1'b0;
        w_par_fail  = 1'b0;
        if (w_timeout) begin
            w_state_nxt = ST_IDLE;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_dat_s2) begin
                        w_state_nxt = ST_DATA;
                        w_cnt_nxt   = '0;
                        w_par_nxt   = 1'b1;
                        w_perr_nxt  = 1'b0;
                    end
                end
                ST_DATA: begin
                    w_shift_nxt[r_bitcnt] = r_dat_s2;
                    w_par_nxt             = r_par ^ r_dat_s2;
                    w_cnt_nxt             = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'(PS2_DATA_BITS - 1)) begin
                        w_state_nxt = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    w_perr_nxt  = (r_dat_s2 != r_par);
                    w_state_nxt = ST_STOP;
                end
                ST_STOP: begin
                    // A bad stop bit outranks a parity error from the same frame.
                    if (!r_dat_s2) begin
                        w_frame_err = 1'b1;
                    end else if (r_perr) begin
                        w_par_fail = 1'b1;
                    end else begin
                        w_push = 1'b1;
                    end
                    w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    ps2_rx_fifo #(
        .FIFO_BITS (FIFO_BITS)
    ) u_fifo (
        .clk        (clk_sys),
        .rst_n      (reset_n),
        .i_push     (w_push),
        .i_data     (r_shift),
        .i_pop      (rx_ready),
        .o_data     (rx_data),
        .o_valid    (rx_valid),
        .o_full     (w_full),
        .o_overflow (w_ovf),
        .o_count    (fifo_count)
    );

    always_comb begin
        w_code = ERR_TIMEOUT;
        if (w_ovf) begin
            w_code = ERR_OVERFLOW;
        end else if (w_frame_err) begin
            w_code = ERR_FRAME;
        end else if (w_par_fail) begin
            w_code = ERR_PARITY;
        end
    end

    assign w_err_any = w_timeout | w_frame_err | w_par_fail | w_ovf;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_err  <= 1'b0;
            r_code <= '0;
        end else begin
            r_err <= w_err_any;
            if (w_err_any) begin
                r_code <= w_code;
            end
        end
    end

    assign rx_err      = r_err;
    assign rx_err_code = r_code;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx.sv
`default_nettype none
//==============================================================================
// tb_ps2_rx - randomized frame bench for ps2_rx against a queue-based byte model. Rev 1.0
//==============================================================================
module tb_ps2_rx;

    localparam int FB = 3;
    localparam int TO = 8192;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         ps2_clk = 1'b1;
    logic         ps2_data = 1'b1;
    logic         rx_ready = 1'b0;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_err;
    logic [1:0]   rx_err_code;
    logic [FB:0]  fifo_count;

    ps2_rx #(.FIFO_BITS(FB), .TIMEOUT(TO)) dut (
        .clk_sys     (clk),
        .reset_n     (reset_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_err      (rx_err),
        .rx_err_code (rx_err_code),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         err_cnt  = 0;
    int         last_err_cyc = 0;
    int         fall_cyc = 0;
    logic [1:0] last_code = 2'd0;
    logic [7:0] q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_err) begin
            err_cnt      = err_cnt + 1;
            last_code    = rx_err_code;
            last_err_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        bit p;
        p = ($countones(d) % 2 == 0);
        return {~bad_stop, p ^ bad_par, d, 1'b0};
    endfunction

    // Expected outcome of a whole frame: -1 = byte queued, else error code.
    function automatic int model_frame(input logic [10:0] f, input bit pop);
        if (f[10] == 1'b0) return 2;
        if (f[9] != ($countones(f[8:1]) % 2 == 0)) return 1;
        if (pop) void'(q.pop_front());
        if (q.size() == (1 << FB)) return 3;
        q.push_back(f[8:1]);
        return -1;
    endfunction

    task automatic send(input logic [10:0] f, input int first, input int last, input bit pop_at_stop);
        for (int i = first; i < last; i++) begin
            int h;
            h = $urandom_range(4, 9);
            ps2_data = f[i];
            repeat (h) @(negedge clk);
            ps2_clk  = 1'b0;
            fall_cyc = cyc;
            if (pop_at_stop && i == 10) begin
                repeat (2) @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
                repeat (h - 3) @(negedge clk);
            end else begin
                repeat (h) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic verify(input int exp, input int base);
        if (exp < 0) begin
            check("err_none", err_cnt - base, 0);
        end else begin
            check("err_pulse", err_cnt - base, 1);
            check("err_code", last_code, exp);
        end
        check("count", fifo_count, q.size());
        check("valid", rx_valid, q.size() != 0);
        if (q.size() != 0) check("head", rx_data, q[0]);
    endtask

    task automatic frame(input logic [7:0] d, input bit bad_par, input bit bad_stop, input bit pop);
        logic [10:0] f;
        int base, exp;
        f = mk_frame(d, bad_par, bad_stop);
        if (pop) check("pop_head", rx_data, q[0]);
        base = err_cnt;
        exp  = model_frame(f, pop);
        send(f, 0, 11, pop);
        repeat (8) @(negedge clk);
        verify(exp, base);
    endtask

    task automatic pop_one();
        check("pop_valid", rx_valid, 1);
        check("pop_data", rx_data, q[0]);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        void'(q.pop_front());
        @(negedge clk);
        check("pop_count", fifo_count, q.size());
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] f;
        int base;

        repeat (3) @(negedge clk);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_count", fifo_count, 0);
        check("rst_err", rx_err, 0);
        check("rst_code", rx_err_code, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        frame(8'h1C, 0, 0, 0);
        pop_one();
        check("empty_after_pop", rx_valid, 0);
        frame(8'h1C, 1, 0, 0);
        frame(8'hAA, 0, 1, 0);
        frame(8'hF0, 0, 0, 0);
        pop_one();

        // Single fall with data high in IDLE is ignored.
        base = err_cnt;
        send(11'h7FF, 0, 1, 0);
        repeat (8) @(negedge clk);
        verify(-1, base);
        frame(8'h3A, 0, 0, 0);
        pop_one();

        for (int d = 1; d <= 9; d++) frame(8'(d), 0, 0, 0);
        while (q.size() != 0) pop_one();
        for (int k = 0; k < 8; k++) frame(8'($urandom), 0, 0, 0);
        frame(8'h55, 0, 0, 1);
        check("last_is_55", q[q.size()-1], 8'h55);
        while (q.size() != 0) pop_one();

        for (int k = 0; k < 24; k++) begin
            int kind;
            kind = $urandom_range(0, 5);
            frame(8'($urandom), kind == 0 || kind == 2, kind == 1 || kind == 2, 0);
            if (q.size() >= 6 || ($urandom % 2) == 1) begin
                int n;
                n = $urandom_range(1, q.size() > 0 ? q.size() : 1);
                for (int j = 0; j < n && q.size() != 0; j++) pop_one();
            end
        end
        while (q.size() != 0) pop_one();

        f    = mk_frame(8'h5A, 0, 0);
        base = err_cnt;
        send(f, 0, 5, 0);
`ifdef PS2_RX_TIMEOUT_EN
        repeat (TO + 10) @(negedge clk);
        check("to_pulse", err_cnt - base, 1);
        check("to_code", last_code, 0);
        check("to_delay", last_err_cyc - fall_cyc, TO + 3);
        frame(8'h5A, 0, 0, 0);
`else
        repeat (TO + 10) @(negedge clk);
        check("no_to_err", err_cnt - base, 0);
        send(f, 5, 11, 0);
        repeat (8) @(negedge clk);
        q.push_back(8'h5A);
        verify(-1, base);
`endif
        pop_one();

        frame(8'h77, 0, 0, 0);
        send(mk_frame(8'h12, 0, 0), 0, 4, 0);
        reset_n = 1'b0;
        @(negedge clk);
        q.delete();
        check("mid_rst_valid", rx_valid, 0);
        check("mid_rst_data", rx_data, 0);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_err", rx_err, 0);
        check("mid_rst_code", rx_err_code, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        frame(8'h3C, 0, 0, 0);
        pop_one();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
